wb_pattern_tester: RTL and testbench

WB_PATTERN_TESTER -- requirements
Module: wb_pattern_tester

---
 rtl/wb_pattern_tester.sv | 161 ++++++++++++++++
 tb/tb_wb_pattern_tester.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pattern_tester.sv
// Wishbone classic master that writes an incrementing pattern into a window,
// reads it back, and reports mismatches, first failing address and ack timeouts.
module wb_pattern_tester #(
    parameter int APP_AW = 26,
    parameter int DW     = 32,
    parameter int TO_CYC = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              sdr_init_done,
    input  logic [APP_AW-1:0] cfg_base,
    input  logic [15:0]       cfg_len,
    input  logic [DW-1:0]     cfg_seed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [APP_AW-1:0] err_addr
);

    // state     | meaning
    // IDLE      | waiting for start
    // WAIT_INIT | run accepted, waiting for SDRAM init
    // WR        | write beat on the bus
    // WR_GAP    | one idle cycle after a write ack
    // RD        | read beat on the bus
    // RD_GAP    | one idle cycle after a read ack
    // FIN       | done pulse, result valid
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR, S_WR_GAP, S_RD, S_RD_GAP, S_FIN
    } state_t;

    localparam int TW = $clog2(TO_CYC + 1);

    state_t            state, state_nxt;
    logic [APP_AW-1:0] base_q, addr_q;
    logic [DW-1:0]     seed_q, dat_q;
    logic [15:0]       len_q, idx_q;
    logic [TW-1:0]     wait_q;
    logic              access, acked, expired, last_word;
    logic [APP_AW-1:0] base_aligned;

    assign access       = (state == S_WR) || (state == S_RD);
    assign acked        = access && wb_ack_i;
    // An ack in the terminal cycle wins over the timeout.
    assign expired      = access && !wb_ack_i && (wait_q == '0);
    assign last_word    = ({1'b0, idx_q} + 17'd1) >= {1'b0, len_q};
    assign base_aligned = cfg_base & ~APP_AW'(3);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wb_cyc_o  = access;
        wb_stb_o  = access;
        wb_we_o   = (state == S_WR);
        wb_addr_o = access ? addr_q : '0;
        wb_dat_o  = (state == S_WR) ? dat_q : '0;
        wb_sel_o  = {(DW/8){access}};
        wb_cti_o  = 3'b000;
        busy      = (state != S_IDLE) && (state != S_FIN);
        done      = (state == S_FIN);
        unique case (state)
            S_IDLE:      if (start) state_nxt = (cfg_len == 16'd0) ? S_FIN : S_WAIT_INIT;
            S_WAIT_INIT: if (sdr_init_done) state_nxt = S_WR;
            S_WR: begin
                if (acked)        state_nxt = S_WR_GAP;
                else if (expired) state_nxt = S_FIN;
            end
            S_WR_GAP:    state_nxt = last_word ? S_RD : S_WR;
            S_RD: begin
                if (acked)        state_nxt = S_RD_GAP;
                else if (expired) state_nxt = S_FIN;
            end
            S_RD_GAP:    state_nxt = last_word ? S_FIN : S_RD;
            S_FIN:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            base_q   <= '0;
            addr_q   <= '0;
            seed_q   <= '0;
            dat_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            wait_q   <= '0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            // Down-counter reloads whenever no access is in flight.
            if (!access)             wait_q <= TW'(TO_CYC - 1);
            else if (wait_q != '0)   wait_q <= wait_q - 1'b1;

            if (expired) timeout <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_aligned;
                        addr_q   <= base_aligned;
                        seed_q   <= cfg_seed;
                        dat_q    <= cfg_seed;
                        len_q    <= cfg_len;
                        idx_q    <= '0;
                        err_cnt  <= '0;
                        err_addr <= '0;
                        timeout  <= 1'b0;
                        pass     <= (cfg_len == 16'd0);
                    end
                end
                S_WR_GAP: begin
                    if (last_word) begin
                        idx_q  <= '0;
                        addr_q <= base_q;
                        dat_q  <= seed_q;
                    end else begin
                        idx_q  <= idx_q + 16'd1;
                        addr_q <= addr_q + APP_AW'(4);
                        dat_q  <= dat_q + DW'(1);
                    end
                end
                S_RD: begin
                    if (acked && (wb_dat_i != dat_q)) begin
                        if (err_cnt != 16'hFFFF) err_cnt  <= err_cnt + 16'd1;
                        if (err_cnt == 16'd0)    err_addr <= addr_q;
                    end
                end
                S_RD_GAP: begin
                    if (last_word) begin
                        pass <= (err_cnt == 16'd0);
                    end else begin
                        idx_q  <= idx_q + 16'd1;
                        addr_q <= addr_q + APP_AW'(4);
                        dat_q  <= dat_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_pattern_tester.sv
// Directed bench for wb_pattern_tester: a transaction-list model of the
// expected bus accesses plus per-run result checks against literal values.
module tb_wb_pattern_tester;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          init_done = 1'b1;
    logic [AW-1:0] cfg_base = '0;
    logic [15:0]   cfg_len = '0;
    logic [DW-1:0] cfg_seed = '0;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] err_addr;

    int total = 0;
    int bad = 0;

    // slave controls
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic          block_en = 1'b0;
    logic [AW-1:0] block_addr = '0;
    logic          stray_ack = 1'b0;
    int            ack_wait = 0;
    int            stb_cnt = 0;
    logic [DW-1:0] mem [64];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } acc_t;
    acc_t          exp_q[$];
    int            exp_err;
    logic [AW-1:0] exp_err_addr;

    wb_pattern_tester #(.APP_AW(AW), .DW(DW), .TO_CYC(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .sdr_init_done(init_done),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(ack), .wb_dat_i(rdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    assign ack = (wb_cyc_o && wb_stb_o && (stb_cnt >= ack_wait)
                  && !(block_en && (wb_addr_o == block_addr))) || stray_ack;
    assign rdata = mem[wb_addr_o[7:2]]
                   ^ ((corrupt_en && (wb_addr_o == corrupt_addr)) ? 32'h1 : 32'h0);

    logic [113:0] all_out;
    assign all_out = {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o,
                      wb_cti_o, busy, done, pass, timeout, err_cnt, err_addr};

    always @(posedge clk) begin
        if (wb_cyc_o && !ack) stb_cnt <= stb_cnt + 1;
        else                  stb_cnt <= 0;
        if (wb_cyc_o && ack && wb_we_o) mem[wb_addr_o[7:2]] <= wb_dat_o;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected access list: len writes then len reads, word i at base+4i, data seed+i.
    task automatic build_model(input logic [AW-1:0] b, input logic [15:0] l, input logic [DW-1:0] s);
        logic [63:0] a;
        acc_t e;
        exp_q.delete();
        exp_err = 0;
        exp_err_addr = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < int'(l); i++) begin
                a = 64'(b & ~AW'(3)) + 64'(4 * i);
                e.we = (ph == 0);
                e.addr = a[AW-1:0];
                e.dat = s + DW'(i);
                exp_q.push_back(e);
                if (ph == 1 && corrupt_en && e.addr == corrupt_addr) begin
                    if (exp_err == 0) exp_err_addr = e.addr;
                    exp_err++;
                end
            end
        end
    endtask

    logic prev_acc = 1'b0;
    always @(negedge clk) begin
        acc_t e;
        if (rst) begin
            prev_acc <= 1'b0;
        end else begin
            if (prev_acc) check("gap_cyc_low", wb_cyc_o, 0);
            if (wb_cyc_o) begin
                check("stb_eq_cyc", wb_stb_o, 1);
                check("sel_all", wb_sel_o, 4'hF);
                check("cti_classic", wb_cti_o, 0);
            end
            if (wb_cyc_o && ack) begin
                check("access_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("acc_we", wb_we_o, e.we);
                    check("acc_addr", wb_addr_o, e.addr);
                    if (e.we) check("acc_wdat", wb_dat_o, e.dat);
                end
            end
            prev_acc <= wb_cyc_o && ack;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [15:0] l, input logic [DW-1:0] s);
        @(negedge clk);
        cfg_base = b; cfg_len = l; cfg_seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int cyc_hi);
        n = 1;
        cyc_hi = 0;
        while (!done && n < 2000) begin
            if (wb_cyc_o) cyc_hi++;
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int n, ch, busy_lo, done_cnt, k;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", all_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("no_cyc_after_release", wb_cyc_o, 0);

        // 1: basic zero-wait run
        build_model(26'h100, 16'd4, 32'hA5A50000);
        check("model_w2_addr", exp_q[2].addr, 26'h108);
        check("model_w3_dat", exp_q[3].dat, 32'hA5A50003);
        check("model_r0_we", exp_q[4].we, 0);
        do_start(26'h100, 16'd4, 32'hA5A50000);
        check("t1_busy", busy, 1);
        wait_done(n, ch);
        check("t1_done_cycle", n, 18);
        check("t1_cyc_cycles", ch, 8);
        check("t1_pass", pass, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_timeout", timeout, 0);
        check("t1_busy_fin", busy, 0);
        check("t1_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);
        check("t1_pass_hold", pass, 1);

        // 2: corrupted read of 0x108
        corrupt_en = 1'b1; corrupt_addr = 26'h108;
        build_model(26'h100, 16'd4, 32'hA5A50000);
        do_start(26'h100, 16'd4, 32'hA5A50000);
        wait_done(n, ch);
        check("t2_done_cycle", n, 18);
        check("t2_err_cnt_lit", err_cnt, 1);
        check("t2_err_addr_lit", err_addr, 26'h108);
        check("t2_err_cnt_model", err_cnt, exp_err);
        check("t2_err_addr_model", err_addr, exp_err_addr);
        check("t2_pass", pass, 0);
        @(negedge clk);
        check("t2_err_hold", err_cnt, 1);
        corrupt_en = 1'b0;

        // 3: init gating, unaligned base, start ignored while busy
        init_done = 1'b0;
        build_model(26'h203, 16'd2, 32'h12345678);
        check("model_t3_addr", exp_q[1].addr, 26'h204);
        check("model_t3_dat", exp_q[3].dat, 32'h12345679);
        do_start(26'h203, 16'd2, 32'h12345678);
        ch = 0; busy_lo = 0; done_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (wb_cyc_o) ch++;
            if (!busy) busy_lo++;
            if (done) done_cnt++;
            if (c == 10) begin start = 1'b1; cfg_len = 16'd0; end
            if (c == 11) begin start = 1'b0; cfg_len = 16'd2; end
            @(negedge clk);
        end
        check("t3_cyc_while_wait", ch, 0);
        check("t3_busy_low_cycles", busy_lo, 0);
        check("t3_done_while_wait", done_cnt, 0);
        init_done = 1'b1;
        @(negedge clk);
        check("t3_first_wr", {wb_cyc_o, wb_we_o, wb_addr_o}, {2'b11, 26'h200});
        wait_done(n, ch);
        check("t3_pass", pass, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: second write never acked
        block_en = 1'b1; block_addr = 26'h104;
        build_model(26'h100, 16'd4, 32'h0BAD0000);
        do_start(26'h100, 16'd4, 32'h0BAD0000);
        wait_done(n, ch);
        check("t4_done_cycle", n, 20);
        check("t4_cyc_cycles", ch, 17);
        check("t4_timeout", timeout, 1);
        check("t4_pass", pass, 0);
        check("t4_cyc_dropped", wb_cyc_o, 0);
        block_en = 1'b0;
        exp_q.delete();

        // 4b: ack exactly in the last allowed cycle is a normal ack
        ack_wait = TO - 1;
        build_model(26'h0, 16'd2, 32'hFFFFFFFF);
        check("model_t4b_wrap_dat", exp_q[1].dat, 32'h0);
        do_start(26'h0, 16'd2, 32'hFFFFFFFF);
        wait_done(n, ch);
        check("t4b_done_cycle", n, 70);
        check("t4b_timeout", timeout, 0);
        check("t4b_pass", pass, 1);
        check("t4b_queue_empty", exp_q.size(), 0);
        ack_wait = 0;

        // 5: address wrap, stray acks while idle/gap
        stray_ack = 1'b1;
        build_model(26'h3FFFFFC, 16'd2, 32'hCAFE0000);
        check("model_t5_wrap_addr", exp_q[1].addr, 26'h0);
        do_start(26'h3FFFFFC, 16'd2, 32'hCAFE0000);
        wait_done(n, ch);
        check("t5_done_cycle", n, 10);
        check("t5_pass", pass, 1);
        check("t5_queue_empty", exp_q.size(), 0);
        stray_ack = 1'b0;

        // 6: reset mid-read, then zero-length run
        build_model(26'h300, 16'd4, 32'h55AA0000);
        do_start(26'h300, 16'd4, 32'h55AA0000);
        k = 0;
        while (!(wb_cyc_o && !wb_we_o) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_reached_rd", wb_cyc_o && !wb_we_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs_zero", all_out, 0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_cyc_after_release", wb_cyc_o, 0);
        do_start(26'h300, 16'd0, 32'h55AA0000);
        check("t6_len0_done", done, 1);
        check("t6_len0_pass", pass, 1);
        check("t6_len0_no_cyc", wb_cyc_o, 0);
        check("t6_len0_busy", busy, 0);
        @(negedge clk);
        check("t6_len0_done_once", done, 0);
        check("t6_len0_pass_hold", pass, 1);
        check("t6_len0_no_cyc2", wb_cyc_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
